// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths: FSM state encoding,
// data/counter widths and the bit-period calculation.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = 16;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_t;

  // Clocks per bit; integer division truncates toward a slightly fast bit rate.
  function automatic int unsigned uart_bps_cnt(input int unsigned clk_fre,
                                               input int unsigned uart_bps);
    return clk_fre / uart_bps;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BPS_CNT-1, raises tick on the last count, and
// restarts from 0 after a tick or whenever clear is high.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned BPS_CNT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [UART_CNT_W-1:0] LAST_CNT = UART_CNT_W'(BPS_CNT - 1);

  if ((BPS_CNT < 2) || (BPS_CNT > ((1 << UART_CNT_W) - 1))) begin : g_bps_range_err
    $error("uart_baud_cnt: BPS_CNT must lie in 2..65535");
  end

  logic [UART_CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = (clear || tick) ? '0 : cnt_q + UART_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter, 8 data bits LSB first, one stop bit, valid/ready byte input.
// Define UART_TX_PARITY_EN to add a parity bit (polarity from PARITY_ODD).
module uart_transmit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 50000000,
  parameter int unsigned UART_BPS   = 9600,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_ready,
  output logic                      uart_t,
  output logic                      uart_done
);

  localparam int unsigned BPS_CNT = uart_bps_cnt(CLK_FRE, UART_BPS);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = UART_TX_IDLE;
  localparam logic [2:0] S_START  = UART_TX_START;
  localparam logic [2:0] S_DATA   = UART_TX_DATA;
  localparam logic [2:0] S_STOP   = UART_TX_STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = UART_TX_PARITY;
  localparam logic       PAR_POL  = (PARITY_ODD != 0);
`endif

  if (PARITY_ODD > 1) begin : g_parity_odd_err
    $error("uart_transmit: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]                state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      tx_ready_q, tx_ready_d;
  logic                      uart_t_q, uart_t_d;
  logic                      uart_done_q, uart_done_d;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif
  logic                      bit_tick;
  logic                      cnt_clear;

  uart_baud_cnt #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .clear (cnt_clear),
    .tick  (bit_tick)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d = tx_data;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ PAR_POL;
`endif
        end
      end
      S_START: if (bit_tick) state_d = S_DATA;
      S_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_tick) state_d = S_STOP;
`endif
      S_STOP: if (bit_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet already
  // show the new bit in the first cycle of each bit period.
  always_comb begin
    case (state_d)
      S_START:  uart_t_d = 1'b0;
      S_DATA:   uart_t_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: uart_t_d = par_d;
`endif
      default:  uart_t_d = 1'b1;
    endcase
    tx_ready_d  = (state_d == S_IDLE);
    uart_done_d = (state_q == S_STOP) && bit_tick;
    cnt_clear   = (state_d != state_q) || (state_q == S_IDLE);
  end

  // NOTE: the shift register is reset too; it is a handful of flops and keeps
  // the state after reset fully defined.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_ready_q  <= 1'b1;
      uart_t_q    <= 1'b1;
      uart_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_ready_q  <= tx_ready_d;
      uart_t_q    <= uart_t_d;
      uart_done_q <= uart_done_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx_ready  = tx_ready_q;
  assign uart_t    = uart_t_q;
  assign uart_done = uart_done_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit at a reduced rate (4 clocks per bit).
module tb_uart_transmit;

  localparam int B = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, uart_t, uart_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  uart_transmit #(
    .CLK_FRE    (1000),
    .UART_BPS   (250),
    .PARITY_ODD (0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .uart_t    (uart_t),
    .uart_done (uart_done)
  );

`ifdef UART_TX_PARITY_EN
  logic       o_valid = 1'b0;
  logic [7:0] o_data  = 8'h00;
  logic       o_ready, o_t, o_done;

  uart_transmit #(
    .CLK_FRE    (1000),
    .UART_BPS   (250),
    .PARITY_ODD (1)
  ) dut_odd (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .tx_valid  (o_valid),
    .tx_data   (o_data),
    .tx_ready  (o_ready),
    .uart_t    (o_t),
    .uart_done (o_done)
  );
`endif

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Expected line level per bit slot: start, d0..d7, [parity], stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic odd);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = (^d) ^ odd;
`endif
    return f;
  endfunction

  // Entered in the cycle whose closing edge accepts d; returns in the uart_done cycle.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] next_d,
                           input bit hold, input int pulse_at, input string tag);
    logic [10:0] f;
    f = make_frame(d, 1'b0);
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_idle: got %b expected 1", tag, tx_ready);
    end
    step();
    if (!hold) tx_valid = 1'b0;
    tx_data = 8'hFF;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_busy: got %b expected 0", tag, tx_ready);
    end
    for (int i = 0; i < FRAME_BITS * B; i++) begin
      n_checks++;
      if (uart_t !== f[i / B]) begin
        n_fail++;
        $display("FAIL %s slot%0d cyc%0d: uart_t got %b expected %b", tag, i / B, i, uart_t, f[i / B]);
      end
      n_checks++;
      if (uart_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s early_done cyc%0d: got %b expected 0", tag, i, uart_done);
      end
      if (i == pulse_at)     tx_valid = 1'b1;
      if (i == pulse_at + 1) tx_valid = 1'b0;
      if (i == FRAME_BITS * B - 1) tx_data = next_d;
      step();
    end
    n_checks++;
    if ({uart_done, tx_ready, uart_t} !== 3'b111) begin
      n_fail++;
      $display("FAIL %s done_cycle: {done,ready,t} got %b expected 111", tag, {uart_done, tx_ready, uart_t});
    end
  endtask

  task automatic test_reset();
    #1 sys_rst = 1'b0;
    #2;
    n_checks++;
    if ({uart_t, tx_ready, uart_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_values: {t,ready,done} got %b expected 110", {uart_t, tx_ready, uart_done});
    end
    step();
    step();
    n_checks++;
    if ({uart_t, tx_ready, uart_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_held: {t,ready,done} got %b expected 110", {uart_t, tx_ready, uart_done});
    end
    sys_rst = 1'b1;
  endtask

  task automatic test_basic();
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    run_frame(8'h55, 8'h00, 1'b0, 2 * B, "basic_55");
    step();
    n_checks++;
    if (uart_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic done_width: got %b expected 0", uart_done);
    end
    // A tx_valid pulse during the busy frame must not start a later frame.
    for (int i = 0; i < 2 * B; i++) begin
      n_checks++;
      if ({uart_t, tx_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL basic no_queue cyc%0d: {t,ready} got %b expected 11", i, {uart_t, tx_ready});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    run_frame(8'hA5, 8'h3C, 1'b1, -10, "b2b_A5");
    run_frame(8'h3C, 8'h00, 1'b0, -10, "b2b_3C");
    step();
    n_checks++;
    if ({uart_done, tx_ready, uart_t} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b after: {done,ready,t} got %b expected 011", {uart_done, tx_ready, uart_t});
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    // Slot 4 is data bit 3; stop halfway through it.
    for (int i = 0; i < 4 * B + B / 2; i++) step();
    n_checks++;
    if (uart_t !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid pre: uart_t got %b expected 0", uart_t);
    end
    #2 sys_rst = 1'b0;
    #1;
    n_checks++;
    if ({uart_t, tx_ready, uart_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL rst_mid async: {t,ready,done} got %b expected 110", {uart_t, tx_ready, uart_done});
    end
    for (int i = 0; i < 2 * B; i++) begin
      step();
      n_checks++;
      if ({uart_t, tx_ready, uart_done} !== 3'b110) begin
        n_fail++;
        $display("FAIL rst_mid held cyc%0d: {t,ready,done} got %b expected 110", i, {uart_t, tx_ready, uart_done});
      end
    end
    sys_rst  = 1'b1;
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    run_frame(8'h81, 8'h00, 1'b0, -10, "rst_81");
    step();
  endtask

  // Independent mid-bit sampling receiver on uart_t.
  task automatic test_loopback();
    logic [7:0] bytes [3];
    logic [7:0] rx;
    bit         found;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h5A;
    for (int n = 0; n < 3; n++) begin
      tx_data  = bytes[n];
      tx_valid = 1'b1;
      found    = 1'b0;
      for (int k = 0; k < 4 * B && !found; k++) begin
        step();
        if (uart_t === 1'b0) found = 1'b1;
      end
      tx_valid = 1'b0;
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL rx%0d start_timeout: no start bit within %0d cycles", n, 4 * B);
      end
      for (int k = 0; k < B / 2; k++) step();
      n_checks++;
      if (uart_t !== 1'b0) begin
        n_fail++;
        $display("FAIL rx%0d start_mid: got %b expected 0", n, uart_t);
      end
      rx = 8'h00;
      for (int j = 0; j < 8; j++) begin
        for (int k = 0; k < B; k++) step();
        rx[j] = uart_t;
      end
`ifdef UART_TX_PARITY_EN
      for (int k = 0; k < B; k++) step();
`endif
      for (int k = 0; k < B; k++) step();
      n_checks++;
      if (uart_t !== 1'b1) begin
        n_fail++;
        $display("FAIL rx%0d stop_mid: got %b expected 1", n, uart_t);
      end
      n_checks++;
      if (rx !== bytes[n]) begin
        n_fail++;
        $display("FAIL rx%0d data: got %h expected %h", n, rx, bytes[n]);
      end
      found = 1'b0;
      for (int k = 0; k < 2 * B && !found; k++) begin
        step();
        if (uart_done === 1'b1) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL rx%0d done_timeout: no uart_done within %0d cycles", n, 2 * B);
      end
      step();
    end
  endtask

  // Run lengths on uart_t for 0xC3 expose any bit that is not exactly B clocks.
  task automatic test_bit_width();
    int runs[$];
    int exp_runs[$];
    logic cur;
    int len;
    bit done_seen;
`ifdef UART_TX_PARITY_EN
    exp_runs = '{4, 8, 16, 8, 4, 4};
`else
    exp_runs = '{4, 8, 16, 12};
`endif
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    step();
    tx_valid  = 1'b0;
    cur       = uart_t;
    len       = 1;
    done_seen = 1'b0;
    for (int k = 0; k < 20 * B && !done_seen; k++) begin
      step();
      if (uart_done === 1'b1) begin
        done_seen = 1'b1;
        runs.push_back(len);
      end else if (uart_t === cur) begin
        len++;
      end else begin
        runs.push_back(len);
        cur = uart_t;
        len = 1;
      end
    end
    n_checks++;
    if (!done_seen || runs.size() != exp_runs.size()) begin
      n_fail++;
      $display("FAIL width_C3 runs: done=%b count got %0d expected %0d", done_seen, runs.size(), exp_runs.size());
    end else begin
      for (int r = 0; r < exp_runs.size(); r++) begin
        n_checks++;
        if (runs[r] != exp_runs[r]) begin
          n_fail++;
          $display("FAIL width_C3 run%0d: got %0d clocks expected %0d", r, runs[r], exp_runs[r]);
        end
      end
    end
    step();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int done_even;
    int done_odd;
    tx_data  = 8'h07;
    o_data   = 8'h07;
    tx_valid = 1'b1;
    o_valid  = 1'b1;
    step();
    tx_valid  = 1'b0;
    o_valid   = 1'b0;
    done_even = 0;
    done_odd  = 0;
    for (int k = 1; k <= 12 * B; k++) begin
      if (k == 9 * B + B / 2) begin
        n_checks++;
        if ({uart_t, o_t} !== 2'b10) begin
          n_fail++;
          $display("FAIL parity_07: {even,odd} got %b expected 10", {uart_t, o_t});
        end
      end
      if (uart_done === 1'b1 && done_even == 0) done_even = k;
      if (o_done === 1'b1 && done_odd == 0) done_odd = k;
      step();
    end
    n_checks++;
    if (done_even != 11 * B + 1 || done_odd != 11 * B + 1) begin
      n_fail++;
      $display("FAIL parity_len: done at even=%0d odd=%0d expected %0d", done_even, done_odd, 11 * B + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_bit_width();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
